// File: rtl/imm_pkg.sv
// Shared types for the decode-stage immediate generator.
// Format codes, major opcodes and the registered payload bundle.
package imm_pkg;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_Z    = 3'd6
   } imm_fmt_e;

   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_FENCE   = 7'b0001111;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_OP32    = 7'b0111011;

   // XLEN-independent part of the payload; imm/target ride alongside it
   typedef struct packed {
      logic [31:0] instr;
      imm_fmt_e    fmt;
      logic        illegal;
   } dec_t;

endpackage

// File: rtl/immgen_pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with registered ready.
// Flush empties both entries and wins over an incoming transfer.
module skid_buf #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_data_o
);

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             skid_valid_q, skid_valid_d;
   logic [WIDTH-1:0] skid_data_q, skid_data_d;
   logic             ready_q, ready_d;
   logic             in_fire, out_fire;

   assign in_fire  = in_valid_i & ready_q & ~flush_i;
   assign out_fire = out_valid_q & out_ready_i;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (flush_i) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else begin
         if (out_fire) begin
            out_valid_d  = skid_valid_q;
            out_data_d   = skid_valid_q ? skid_data_q : out_data_q;
            skid_valid_d = 1'b0;
         end
         // ready_q implies skid is empty, so in_fire never collides with a skid move
         if (in_fire) begin
            if (!out_valid_q || out_fire) begin
               out_valid_d = 1'b1;
               out_data_d  = in_data_i;
            end else begin
               skid_valid_d = 1'b1;
               skid_data_d  = in_data_i;
            end
         end
      end
      ready_d = ~skid_valid_d;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         ready_q      <= 1'b0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         ready_q      <= ready_d;
      end
   end

   assign in_ready_o  = ready_q;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;

endmodule

// File: rtl/immgen_pipe.sv
// Decode-stage immediate generator: combinational decode of format,
// immediate and PC-relative target, registered through a skid buffer.
module immgen_pipe
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [31:0]     instr_i,
   input  logic [XLEN-1:0] pc_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [31:0]     instr_o,
   output logic [XLEN-1:0] imm_o,
   output logic [2:0]      imm_fmt_o,
   output logic [XLEN-1:0] target_o,
   output logic            illegal_o
);

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("immgen_pipe: XLEN must be 32 or 64");
   end

   localparam int W = $bits(dec_t) + 2 * XLEN;

   dec_t            dec;
   dec_t            dec_o;
   logic [31:0]     imm32;
   logic [XLEN-1:0] imm;
   logic [XLEN-1:0] tgt;
   logic            tgt_en;
   logic [W-1:0]    in_data;
   logic [W-1:0]    out_data;

   always_comb begin
      dec.instr   = instr_i;
      dec.fmt     = FMT_NONE;
      dec.illegal = 1'b0;
      tgt_en      = 1'b0;
      if (instr_i[1:0] != 2'b11) begin
         dec.illegal = 1'b1;
      end else begin
         unique case (instr_i[6:0])
            OPC_LOAD, OPC_OPIMM,
            OPC_JALR, OPC_FENCE: dec.fmt = FMT_I;
            OPC_OPIMM32: begin
               if (XLEN == 64) dec.fmt = FMT_I;
               else dec.illegal = 1'b1;
            end
            OPC_STORE: dec.fmt = FMT_S;
            OPC_BRANCH: begin
               dec.fmt = FMT_B;
               tgt_en  = 1'b1;
            end
            OPC_LUI: dec.fmt = FMT_U;
            OPC_AUIPC: begin
               dec.fmt = FMT_U;
               tgt_en  = 1'b1;
            end
            OPC_JAL: begin
               dec.fmt = FMT_J;
               tgt_en  = 1'b1;
            end
            OPC_SYSTEM: dec.fmt = instr_i[14] ? FMT_Z : FMT_I;
            OPC_OP: dec.fmt = FMT_NONE;
            OPC_OP32: begin
               if (XLEN != 64) dec.illegal = 1'b1;
            end
            default: dec.illegal = 1'b1;
         endcase
      end
   end

   always_comb begin
      imm32 = '0;
      unique case (dec.fmt)
         FMT_I: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
         FMT_S: imm32 = {{20{instr_i[31]}}, instr_i[31:25],
                         instr_i[11:7]};
         FMT_B: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};
         FMT_U: imm32 = {instr_i[31:12], 12'b0};
         FMT_J: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                         instr_i[20], instr_i[30:21], 1'b0};
         FMT_Z: imm32 = {27'b0, instr_i[19:15]};
         default: imm32 = '0;
      endcase
   end

   // zimm has bit 31 clear, so sign extension leaves it zero-extended
   assign imm = XLEN'(signed'(imm32));
   assign tgt = tgt_en ? (pc_i + imm) : '0;

   assign in_data = {dec, imm, tgt};

   skid_buf #(
      .WIDTH(W)
   ) u_skid (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .flush_i    (flush_i),
      .in_valid_i (in_valid_i),
      .in_ready_o (in_ready_o),
      .in_data_i  (in_data),
      .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i),
      .out_data_o (out_data)
   );

   assign {dec_o, imm_o, target_o} = out_data;
   assign instr_o   = dec_o.instr;
   assign imm_fmt_o = dec_o.fmt;
   assign illegal_o = dec_o.illegal;

endmodule

// File: tb/tb_immgen_pipe.sv
// Directed bench for immgen_pipe: XLEN=32 and XLEN=64 instances
// share handshake stimulus; expected values are hand-computed.
module tb_immgen_pipe;
   import imm_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] instr = '0;
   logic [63:0] pc = '0;

   logic        rdy32, ov32, ill32;
   logic [31:0] io32, imm32, tgt32;
   logic [2:0]  fmt32;
   logic        rdy64, ov64, ill64;
   logic [31:0] io64;
   logic [63:0] imm64, tgt64;
   logic [2:0]  fmt64;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   immgen_pipe #(.XLEN(32)) u32 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(rdy32),
      .instr_i(instr), .pc_i(pc[31:0]),
      .out_valid_o(ov32), .out_ready_i(out_ready),
      .instr_o(io32), .imm_o(imm32), .imm_fmt_o(fmt32),
      .target_o(tgt32), .illegal_o(ill32)
   );

   immgen_pipe #(.XLEN(64)) u64 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(rdy64),
      .instr_i(instr), .pc_i(pc),
      .out_valid_o(ov64), .out_ready_i(out_ready),
      .instr_o(io64), .imm_o(imm64), .imm_fmt_o(fmt64),
      .target_o(tgt64), .illegal_o(ill64)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one accepted transfer with the output free, result visible next cycle
   task automatic send(input logic [31:0] ins, input logic [63:0] p);
      chk("send_ready", 64'(rdy32), 64'd1);
      instr    = ins;
      pc       = p;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("send_valid", 64'(ov32), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      tick(); tick(); tick();
      chk("rst_valid", 64'(ov32), 64'd0);
      chk("rst_ready", 64'(rdy32), 64'd0);
      chk("rst_fmt", 64'(fmt32), 64'(FMT_NONE));
      chk("rst_imm", 64'(imm32), 64'd0);
      chk("rst_instr", 64'(io32), 64'd0);
      rst = 1'b0;
      tick();
      chk("post_rst_ready", 64'(rdy32), 64'd1);
      chk("post_rst_valid", 64'(ov32), 64'd0);

      send(32'hFFF00093, 64'h0);
      chk("addi_imm", 64'(imm32), 64'hFFFFFFFF);
      chk("addi_fmt", 64'(fmt32), 64'(FMT_I));
      chk("addi_ill", 64'(ill32), 64'd0);
      chk("addi_tgt", 64'(tgt32), 64'd0);

      send(32'hFE000EE3, 64'h100);
      chk("beq_imm", 64'(imm32), 64'hFFFFFFFC);
      chk("beq_fmt", 64'(fmt32), 64'(FMT_B));
      chk("beq_tgt", 64'(tgt32), 64'h000000FC);

      send(32'h0010006F, 64'h1000);
      chk("jal_imm", 64'(imm32), 64'h800);
      chk("jal_fmt", 64'(fmt32), 64'(FMT_J));
      chk("jal_tgt", 64'(tgt32), 64'h1800);

      send(32'h123450B7, 64'h40);
      chk("lui_imm", 64'(imm32), 64'h12345000);
      chk("lui_fmt", 64'(fmt32), 64'(FMT_U));
      chk("lui_tgt", 64'(tgt32), 64'd0);

      // auipc 0x80000 at pc 0x80000000: target wraps to 0
      send(32'h80000097, 64'h80000000);
      chk("auipc_imm", 64'(imm32), 64'h80000000);
      chk("auipc_tgt", 64'(tgt32), 64'd0);
      chk("auipc64_imm", imm64, 64'hFFFFFFFF80000000);

      // sw x2, -8(x1)
      send(32'hFE20AC23, 64'h0);
      chk("sw_imm", 64'(imm32), 64'hFFFFFFF8);
      chk("sw_fmt", 64'(fmt32), 64'(FMT_S));

      // csrrwi x0, 0x300, 31
      send(32'h300FD073, 64'h0);
      chk("csri_imm", 64'(imm32), 64'd31);
      chk("csri_fmt", 64'(fmt32), 64'(FMT_Z));

      // add x1, x2, x3
      send(32'h003100B3, 64'h0);
      chk("add_fmt", 64'(fmt32), 64'(FMT_NONE));
      chk("add_imm", 64'(imm32), 64'd0);
      chk("add_ill", 64'(ill32), 64'd0);

      send(32'h00000000, 64'h0);
      chk("zero_ill", 64'(ill32), 64'd1);
      chk("zero_imm", 64'(imm32), 64'd0);
      chk("zero_fmt", 64'(fmt32), 64'(FMT_NONE));

      // addiw x1, x0, 1
      send(32'h0010009B, 64'h0);
      chk("opimm32_ill32", 64'(ill32), 64'd1);
      chk("opimm32_fmt32", 64'(fmt32), 64'(FMT_NONE));
      chk("opimm32_ill64", 64'(ill64), 64'd0);
      chk("opimm32_fmt64", 64'(fmt64), 64'(FMT_I));
      chk("opimm32_imm64", imm64, 64'd1);

      tick();
      chk("drained", 64'(ov32), 64'd0);

      // back-pressure: #1 on output, #2 in skid, #3 stalled
      out_ready = 1'b0;
      in_valid  = 1'b1;
      instr     = 32'h00100093;
      tick();
      instr = 32'h00200093;
      tick();
      instr = 32'h00300093;
      tick();
      chk("bp_hold_valid", 64'(ov32), 64'd1);
      chk("bp_hold_instr", 64'(io32), 64'h00100093);
      chk("bp_ready_low", 64'(rdy32), 64'd0);
      out_ready = 1'b1;
      tick();
      chk("bp_out2_valid", 64'(ov32), 64'd1);
      chk("bp_out2_instr", 64'(io32), 64'h00200093);
      chk("bp_ready_back", 64'(rdy32), 64'd1);
      tick();
      in_valid = 1'b0;
      chk("bp_out3_valid", 64'(ov32), 64'd1);
      chk("bp_out3_instr", 64'(io32), 64'h00300093);
      chk("bp_out3_imm", 64'(imm32), 64'd3);
      tick();
      chk("bp_empty", 64'(ov32), 64'd0);

      // flush with two entries held
      out_ready = 1'b0;
      in_valid  = 1'b1;
      instr     = 32'h00500093;
      tick();
      instr = 32'h00600093;
      tick();
      chk("fl_full_ready", 64'(rdy32), 64'd0);
      flush = 1'b1;
      instr = 32'h00700093;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("fl_valid", 64'(ov32), 64'd0);
      chk("fl_ready", 64'(rdy32), 64'd1);
      out_ready = 1'b1;
      tick();
      tick();
      chk("fl_stays_empty", 64'(ov32), 64'd0);

      // flush while ready is high: the presented input is discarded
      out_ready = 1'b0;
      in_valid  = 1'b1;
      instr     = 32'h00800093;
      tick();
      flush = 1'b1;
      instr = 32'h00900093;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("fl1_valid", 64'(ov32), 64'd0);
      out_ready = 1'b1;
      tick();
      chk("fl1_no_ghost", 64'(ov32), 64'd0);

      // reset mid-operation with two entries held
      out_ready = 1'b0;
      in_valid  = 1'b1;
      instr     = 32'hFE000EE3;
      pc        = 64'h100;
      tick();
      instr = 32'h0010006F;
      tick();
      rst   = 1'b1;
      instr = 32'h00A00093;
      tick();
      in_valid = 1'b0;
      chk("mrst_valid", 64'(ov32), 64'd0);
      chk("mrst_ready", 64'(rdy32), 64'd0);
      chk("mrst_instr", 64'(io32), 64'd0);
      chk("mrst_imm", 64'(imm32), 64'd0);
      chk("mrst_tgt", 64'(tgt32), 64'd0);
      chk("mrst_fmt", 64'(fmt32), 64'(FMT_NONE));
      chk("mrst_ill", 64'(ill32), 64'd0);
      rst       = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("mrst_ready_after", 64'(rdy32), 64'd1);
      chk("mrst_empty_after", 64'(ov32), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
